// File: rtl/out_port_bank.sv
// Four-port output receiver bank: each CPU port write lands in a per-port FIFO
// that drains over valid/ready. Sticky overflow flags exist only with OUT_PORT_OVF_EN.
module out_port_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable0,
    input  logic               enable1,
    input  logic               enable2,
    input  logic               enable3,
    input  logic [WIDTH-1:0]   data_in,
    output logic [4*WIDTH-1:0] port_data,
    output logic [3:0]         port_valid,
    input  logic [3:0]         port_ready,
    output logic [3:0]         port_full,
    output logic [3:0]         ovf,
    input  logic               ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0] en;
    logic [3:0] drop;

    assign en = {enable3, enable2, enable1, enable0};

    for (genvar g = 0; g < 4; g++) begin : g_port
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_q, wr_d;
        logic [PW-1:0]    rd_q, rd_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             push;
        logic             pop;

        assign port_valid[g] = (cnt_q != '0);
        assign port_full[g]  = (cnt_q == CW'(DEPTH));

        assign pop     = port_valid[g] & port_ready[g];
        assign push    = en[g] & (~port_full[g] | pop);
        assign drop[g] = en[g] & port_full[g] & ~pop;

        // Head is masked while empty so outputs read 0 after reset.
        assign port_data[g*WIDTH +: WIDTH] =
            port_valid[g] ? mem_q[rd_q] : '0;

        always_comb begin
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push && !reset) begin
                mem_q[wr_q] <= data_in;
            end
        end
    end

`ifdef OUT_PORT_OVF_EN
    logic [3:0] ovf_q, ovf_d;

    // A new drop beats a clear arriving in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = '0;
        ovf_d = ovf_d | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;

    assign unused_ovf = ovf_clr ^ (^drop);
    assign ovf        = '0;
`endif

endmodule

// File: tb/tb_out_port_bank.sv
// Directed bench for out_port_bank: queue-based model checked every cycle,
// plus literal checks for each scenario.
module tb_out_port_bank;

    localparam int W = 8;
    localparam int D = 4;
`ifdef OUT_PORT_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     en = '0;
    logic [W-1:0]   din = '0;
    logic [4*W-1:0] pdata;
    logic [3:0]     pvalid;
    logic [3:0]     rdy = '0;
    logic [3:0]     pfull;
    logic [3:0]     povf;
    logic           clr = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    logic [W-1:0] mq [4][$];
    bit   [3:0]   movf = '0;

    out_port_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (rst),
        .enable0    (en[0]),
        .enable1    (en[1]),
        .enable2    (en[2]),
        .enable3    (en[3]),
        .data_in    (din),
        .port_data  (pdata),
        .port_valid (pvalid),
        .port_ready (rdy),
        .port_full  (pfull),
        .ovf        (povf),
        .ovf_clr    (clr)
    );

    always #5 clk = ~clk;

    // Model: plain queues, one push/pop decision per port per edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) mq[n].delete();
            movf = '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                bit full, pop, push, ev;
                full = (mq[n].size() == D);
                pop  = (mq[n].size() > 0) && rdy[n];
                push = en[n] && (!full || pop);
                ev   = en[n] && full && !pop;
                if (pop)  void'(mq[n].pop_front());
                if (push) mq[n].push_back(din);
                if (ev) movf[n] = 1'b1;
                else if (clr) movf[n] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [3:0] ev, ef, eo;
            for (int n = 0; n < 4; n++) begin
                ev[n] = (mq[n].size() > 0);
                ef[n] = (mq[n].size() == D);
            end
            eo = OVF_ON ? movf : 4'b0000;
            checks++;
            if (pvalid !== ev) begin
                errors++;
                $display("FAIL model_valid got=%b exp=%b t=%0t", pvalid, ev, $time);
            end
            checks++;
            if (pfull !== ef) begin
                errors++;
                $display("FAIL model_full got=%b exp=%b t=%0t", pfull, ef, $time);
            end
            checks++;
            if (povf !== eo) begin
                errors++;
                $display("FAIL model_ovf got=%b exp=%b t=%0t", povf, eo, $time);
            end
            for (int n = 0; n < 4; n++) begin
                if (mq[n].size() > 0) begin
                    checks++;
                    if (pdata[n*W +: W] !== mq[n][0]) begin
                        errors++;
                        $display("FAIL model_data%0d got=%h exp=%h t=%0t",
                                 n, pdata[n*W +: W], mq[n][0], $time);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] e, input logic [W-1:0] d,
                       input logic [3:0] r, input logic c, input logic rs);
        @(negedge clk);
        en  = e;
        din = d;
        rdy = r;
        clr = c;
        rst = rs;
    endtask

    task automatic idle();
        cyc(4'b0000, '0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        logic [W-1:0] p3_exp [4];

        cyc(4'b0000, '0, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, '0, 4'b1111, 1'b0, 1'b1);
        idle();
        chk_on = 1'b1;
        chk("rst_valid", 32'(pvalid), 32'h0);
        chk("rst_full", 32'(pfull), 32'h0);
        chk("rst_ovf", 32'(povf), 32'h0);
        chk("rst_data", pdata, 32'h0);

        cyc(4'b0100, 8'hA5, 4'b0000, 1'b0, 1'b0);
        idle();
        chk("p2_valid", 32'(pvalid), 32'h4);
        chk("p2_data", 32'(pdata[23:16]), 32'hA5);

        for (int i = 0; i < 4; i++)
            cyc(4'b0001, W'(i + 1), 4'b0000, 1'b0, 1'b0);
        idle();
        chk("p0_full", 32'(pfull[0]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000, '0, 4'b0001, 1'b0, 1'b0);
            chk("p0_drain", 32'(pdata[7:0]), 32'(i + 1));
        end
        idle();
        chk("p0_empty", 32'(pvalid[0]), 32'h0);

        for (int i = 0; i < 4; i++)
            cyc(4'b0010, W'(8'h10 + i), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0010, 8'hFF, 4'b0000, 1'b0, 1'b0);
        idle();
        chk("p1_ovf", 32'(povf), OVF_ON ? 32'h2 : 32'h0);
        chk("p1_full", 32'(pfull[1]), 32'h1);
        cyc(4'b0000, '0, 4'b0000, 1'b1, 1'b0);
        idle();
        chk("ovf_clr", 32'(povf), 32'h0);
        cyc(4'b0010, 8'hEE, 4'b0000, 1'b1, 1'b0);
        idle();
        chk("ovf_beats_clr", 32'(povf), OVF_ON ? 32'h2 : 32'h0);
        cyc(4'b0000, '0, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000, '0, 4'b0010, 1'b0, 1'b0);
            chk("p1_drain", 32'(pdata[15:8]), 32'(8'h10 + i));
        end
        idle();
        chk("p1_empty", 32'(pvalid[1]), 32'h0);

        for (int i = 0; i < 4; i++)
            cyc(4'b1000, W'(8'h30 + i), 4'b0000, 1'b0, 1'b0);
        cyc(4'b1000, 8'h77, 4'b1000, 1'b0, 1'b0);
        idle();
        chk("p3_full", 32'(pfull[3]), 32'h1);
        chk("p3_no_ovf", 32'(povf), 32'h0);
        p3_exp[0] = 8'h31;
        p3_exp[1] = 8'h32;
        p3_exp[2] = 8'h33;
        p3_exp[3] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000, '0, 4'b1000, 1'b0, 1'b0);
            chk("p3_drain", 32'(pdata[31:24]), 32'(p3_exp[i]));
        end
        idle();
        chk("p3_empty", 32'(pvalid[3]), 32'h0);

        cyc(4'b0011, 8'h3C, 4'b0000, 1'b0, 1'b0);
        idle();
        chk("multi_valid", 32'(pvalid), 32'h7);
        chk("multi_data", 32'(pdata[15:0]), 32'h3C3C);

        cyc(4'b0100, 8'hB1, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, '0, 4'b1111, 1'b0, 1'b1);
        idle();
        chk("rst2_valid", 32'(pvalid), 32'h0);
        chk("rst2_data", pdata, 32'h0);
        chk("rst2_full", 32'(pfull), 32'h0);
        cyc(4'b0100, 8'hC7, 4'b0000, 1'b0, 1'b0);
        idle();
        chk("post_rst_valid", 32'(pvalid), 32'h4);
        chk("post_rst_data", 32'(pdata[23:16]), 32'hC7);

        for (int i = 0; i < 80; i++)
            cyc(4'($urandom), W'($urandom), 4'($urandom),
                ($urandom_range(0, 7) == 0), 1'b0);
        for (int i = 0; i < 6; i++)
            cyc(4'b0000, '0, 4'b1111, 1'b0, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
